// File: rtl/mono_pkg.sv
// Shared defaults, FSM encoding and packed-word FIFO entry layout for the mono packer.
// Pure declarations: no latency, no flow control.
package mono_pkg;

    localparam int WORD_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        WAIT_VS = 1'b0,
        RUN     = 1'b1
    } state_t;

    // FIFO entry layout {sof, eol, data}; the packer declares the same layout at its own WORD_W.
    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic [WORD_W_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/mono_sfifo.sv
// Synchronous first-word-fall-through FIFO; push to head visible after one clock.
// Push while full without a pop is dropped and flagged by a one-cycle drop pulse.
module mono_sfifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = pop & ~empty;
    // When full, the write slot is the head being popped this cycle, so it is free to reuse.
    assign do_wr = push & (~full | do_rd);
    assign drop  = push & full & ~do_rd;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mono_packer.sv
// Packs 1-bit pixels MSB-first into words tagged sof/eol; full word reaches wr_valid 2 cycles after its last pixel.
// Writer back-pressure is absorbed by a small FIFO; pushes into a full FIFO are dropped and set sticky overflow.
module mono_packer
    import mono_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mono_vsync,
    input  logic              mono_hsync,
    input  logic              mono_de,
    input  logic              monoc,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_sof,
    output logic              wr_eol,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              overflow
);

    localparam int CNT_W = $clog2(WORD_W);

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [WORD_W-1:0] data;
    } word_ent_t;

    state_t            state;
    state_t            state_nxt;
    logic              vsync_d;
    logic              de_d;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] shreg;
    logic              full_pend;
    logic              sof_pend;

    logic              run;
    logic              vs_rise;
    logic              pix_en;
    logic              part_push;
    logic [WORD_W-1:0] part_word;
    logic              push;
    word_ent_t         push_ent;
    word_ent_t         head_ent;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              pop;

    // Line boundaries come from de alone.
    logic unused_hsync;
    assign unused_hsync = mono_hsync;

    assign run       = (state == RUN);
    assign vs_rise   = mono_vsync & ~vsync_d;
    assign pix_en    = run & ~vs_rise & mono_de;
    assign part_push = run & ~vs_rise & de_d & ~mono_de & (cnt != '0);
    assign part_word = shreg << (WORD_W - int'(cnt));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_VS: if (vs_rise) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = WAIT_VS;
        endcase
    end

    // A completed word is pushed the cycle after its last pixel; eol reflects whether the line continues.
    always_comb begin
        push     = 1'b0;
        push_ent = '0;
        if (full_pend) begin
            push          = 1'b1;
            push_ent.sof  = sof_pend;
            push_ent.eol  = ~mono_de;
            push_ent.data = shreg;
        end else if (part_push) begin
            push          = 1'b1;
            push_ent.sof  = sof_pend;
            push_ent.eol  = 1'b1;
            push_ent.data = part_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d   <= 1'b0;
            de_d      <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            full_pend <= 1'b0;
            sof_pend  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            vsync_d   <= mono_vsync;
            de_d      <= mono_de;
            full_pend <= pix_en && (cnt == CNT_W'(WORD_W - 1));
            if (vs_rise) begin
                cnt   <= '0;
                shreg <= '0;
            end else if (pix_en) begin
                shreg <= {shreg[WORD_W-2:0], monoc};
                cnt   <= cnt + 1'b1;
            end else if (part_push) begin
                cnt   <= '0;
                shreg <= '0;
            end
            // A dropped sof word leaves sof_pend set so the next stored word still opens the frame.
            if (vs_rise) begin
                sof_pend <= 1'b1;
            end else if (push && !fifo_drop) begin
                sof_pend <= 1'b0;
            end
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign wr_valid = ~fifo_empty;
    assign pop      = wr_valid & wr_ready;
    assign wr_data  = head_ent.data;
    assign wr_sof   = head_ent.sof;
    assign wr_eol   = head_ent.eol;

    mono_sfifo #(
        .WIDTH (WORD_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head_ent),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_mono_packer.sv
// Scoreboard bench for mono_packer: stimulus queues expected words, a negedge monitor pops and compares.
module tb_mono_packer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         mono_vsync;
    logic         mono_hsync;
    logic         mono_de;
    logic         monoc;
    logic [W-1:0] wr_data;
    logic         wr_sof;
    logic         wr_eol;
    logic         wr_valid;
    logic         wr_ready;
    logic         overflow;

    typedef struct {
        logic [W-1:0] d;
        logic         sof;
        logic         eol;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mono_packer #(.WORD_W(W), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mono_vsync (mono_vsync),
        .mono_hsync (mono_hsync),
        .mono_de    (mono_de),
        .monoc      (monoc),
        .wr_data    (wr_data),
        .wr_sof     (wr_sof),
        .wr_eol     (wr_eol),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic vs, input logic de, input logic c);
        mono_vsync = vs;
        mono_de    = de;
        monoc      = c;
        mono_hsync = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int b = 0; b < W; b++) begin
            cyc(1'b0, 1'b1, w[W-1-b]);
        end
    endtask

    task automatic expect_word(input logic [W-1:0] d, input logic sof, input logic eol);
        exp_t e;
        e.d   = d;
        e.sof = sof;
        e.eol = eol;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake must match the scoreboard head; a stalled head must not change.
    logic         prev_hold = 1'b0;
    logic [W+2:0] prev_out;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                total++;
                if ({wr_valid, wr_sof, wr_eol, wr_data} !== prev_out) begin
                    bad++;
                    $display("FAIL hold: got %h want %h", {wr_valid, wr_sof, wr_eol, wr_data}, prev_out);
                end
            end
            if (wr_valid && wr_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got data=%h sof=%b eol=%b want none",
                             wr_data, wr_sof, wr_eol);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_data !== e.d || wr_sof !== e.sof || wr_eol !== e.eol) begin
                        bad++;
                        $display("FAIL word: got data=%h sof=%b eol=%b want data=%h sof=%b eol=%b",
                                 wr_data, wr_sof, wr_eol, e.d, e.sof, e.eol);
                    end
                end
            end
            prev_hold = wr_valid && !wr_ready;
            prev_out  = {wr_valid, wr_sof, wr_eol, wr_data};
        end
    end

    logic [31:0]  line32;
    logic [W-1:0] ow [6];

    initial begin
        rst        = 1'b1;
        mono_vsync = 1'b0;
        mono_hsync = 1'b0;
        mono_de    = 1'b0;
        monoc      = 1'b0;
        wr_ready   = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // Reset state
        chk("rst_valid", wr_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_head", {wr_sof, wr_eol, wr_data}, 0);

        // Pixels before any vsync are ignored
        rst      = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, (i % 8) != 7, i[0]);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("pre_vs_valid", wr_valid, 0);

        // 32-pixel line after vsync, latency of the first word
        cyc(1'b1, 1'b0, 1'b0);
        expect_word(16'hA5F0, 1'b1, 1'b0);
        expect_word(16'h0F5A, 1'b0, 1'b1);
        line32 = 32'hA5F0_0F5A;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, line32[31-i]);
            if (i == 15) chk("lat_pre", wr_valid, 0);
            if (i == 16) chk("lat_valid", wr_valid, 1);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // 20 white pixels: full word then left-aligned partial pushed as de falls
        expect_word(16'hFFFF, 1'b0, 1'b0);
        expect_word(16'hF000, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("part_valid", wr_valid, 1);
        chk("part_head", {wr_sof, wr_eol, wr_data}, {2'b01, 16'hF000});
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Back-pressure: 6 words into a 4-deep FIFO
        ow[0] = 16'h1234; ow[1] = 16'h5678; ow[2] = 16'h9ABC;
        ow[3] = 16'hDEF0; ow[4] = 16'h1357; ow[5] = 16'h2468;
        for (int k = 0; k < 4; k++) begin
            expect_word(ow[k], 1'b0, 1'b0);
        end
        wr_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < W; b++) begin
                cyc(1'b0, 1'b1, ow[k][W-1-b]);
                if (k == 4 && b == 15) chk("ovf_before_5th", overflow, 0);
                if (k == 5 && b == 0) chk("ovf_after_5th", overflow, 1);
            end
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("stall_valid", wr_valid, 1);
        chk("stall_head", {wr_sof, wr_eol, wr_data}, {2'b00, 16'h1234});
        wr_ready = 1'b1;
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        chk("drain_valid", wr_valid, 0);
        chk("drain_ovf", overflow, 1);
        chk("drain_count", exp_q.size(), 0);

        // Vsync after 7 pixels discards the partial word and the same-cycle pixel
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
        end
        cyc(1'b1, 1'b1, 1'b1);
        chk("vs_no_push_a", wr_valid, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("vs_no_push_b", wr_valid, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("vs_no_push_c", wr_valid, 0);
        expect_word(16'h3C3C, 1'b1, 1'b1);
        send_word(16'h3C3C);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        // Reset mid-line with 3 words held
        wr_ready = 1'b0;
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
        end
        chk("pre_rst_head", wr_data, 16'h1111);
        chk("pre_rst_ovf", overflow, 1);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        chk("mid_rst_valid", wr_valid, 0);
        chk("mid_rst_ovf", overflow, 0);
        rst      = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("post_rst_ignored", wr_valid, 0);

        // New frame after reset
        cyc(1'b1, 1'b0, 1'b0);
        expect_word(16'h8001, 1'b1, 1'b1);
        send_word(16'h8001);
        cyc(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
